adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one 4-bit add slice (result = r1 + r2 + ci, with carry out) among NREQ requesters.
- Each requester presents operands with a valid/ready handshake. A round-robin arbiter grants one request per accepted cycle, computes the sum, and holds it in a single-entry output register until the consumer takes it.
- Sits between requester logic and the shared adder datapath in the circuit test designs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand/result width in bits.
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i presents an operation.
- req_ready  output  NREQ  bit i: requester i's operation accepted this cycle. One-hot or zero.
- req_r1  input  NREQ*W  first operands; requester i uses bits [i*W +: W].
- req_r2  input  NREQ*W  second operands, same packing.
- req_ci  input  NREQ  carry-in per requester.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_result  output  W  sum bits.
- rsp_carry  output  1  carry out of bit W-1.
- busy_cnt  output  8  saturating count of cycles where some req_valid was high but nothing was accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, busy_cnt=0.
  - Round-robin pointer = 0 (requester 0 has highest priority).
  - req_ready=0 while reset is asserted.
- State: one output slot, EMPTY or FULL, reflected by rsp_valid.
- can_accept = EMPTY or (FULL and rsp_ready).
  - Accepting while the slot drains is a bypass, giving full throughput of one operation per cycle.
- Arbitration is combinational and evaluated every cycle.
  - Search req_valid starting at the pointer, wrapping modulo NREQ. The first set bit is the winner.
  - If can_accept is true and a winner exists, req_ready is the winner's one-hot bit. Otherwise req_ready is zero.
  - req_ready never depends on a requester's own operands. It depends only on req_valid, the pointer, rsp_valid and rsp_ready.
- On an accepting edge:
  - rsp_result and rsp_carry load {carry, result} = r1 + r2 + ci of the winner, computed at W+1 bits with no truncation before the carry is taken.
  - rsp_id loads the winner index and rsp_valid goes to 1.
  - Pointer loads (winner+1) mod NREQ.
- On a non-accepting edge:
  - If FULL and rsp_ready: rsp_valid goes to 0. The payload holds its last value.
  - If FULL and not rsp_ready: everything holds. The payload is stable while rsp_valid is high and rsp_ready is low.
  - The pointer never moves without an accept.
- Latency: an operation accepted at edge t is visible on rsp_* after edge t (next cycle).
- busy_cnt increments on any edge where some req_valid bit is 1 and no request was accepted. It saturates at 255 and never wraps.
- Requesters may drop req_valid without being accepted. No state is kept per requester.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and rsp_valid stays 1. No bubble and no duplication.
- Reset asserted mid-operation: a pending result is discarded, and after release the block behaves as freshly reset.
- An rsp_id value at or above NREQ is never produced.

Test Plan:
- Reset with all req_valid=1 -> req_ready=0 during reset. After release with rsp_ready=1, the first grant is requester 0, then 1, 2, 3, 0 on consecutive cycles with rsp_valid held at 1.
- Requester 2 alone sends r1=4'hF, r2=4'h1, ci=1 -> next cycle rsp_result=4'h1, rsp_carry=1, rsp_id=2.
- Requester 1 sends r1=4'h5, r2=4'h3, ci=0 while rsp_ready=0 -> rsp_result=4'h8 and rsp_carry=0 held for 5 cycles. req_ready stays 0 and busy_cnt increments to 5. When rsp_ready rises, a new grant is issued in the same cycle.
- Requesters 0 and 3 both valid with pointer=1 -> requester 3 is granted and the pointer becomes 0. The next grant is requester 0.
- Hold req_valid[1]=1 with rsp_ready=0 for 300 cycles -> busy_cnt saturates at 255.
- Pulse rst_n low while rsp_valid=1 with rsp_result=4'hA -> rsp_valid, rsp_result and busy_cnt go to 0 immediately, without waiting for a clock edge, and the pointer returns to 0.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Requester/consumer bundle for the shared add-slice arbiter.
interface adder_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_r1;
  logic [NREQ*W-1:0] req_r2;
  logic [NREQ-1:0]   req_ci;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_carry;
  logic [7:0]        busy_cnt;

  // Requester/consumer side.
  modport master (
    output req_valid, req_r1, req_r2, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_r1, req_r2, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy_cnt
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one W-bit add slice among NREQ requesters,
// with a single-entry output slot that supports drain-and-refill bypass.
module adder_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adder_share_arbiter_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

  slot_e          slot_q, slot_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   res_q, res_d;
  logic           carry_q, carry_d;
  logic [7:0]     busy_q, busy_d;

  logic           found;
  logic [IDW-1:0] win;
  int unsigned    idx;
  logic           can_accept;
  logic           accept;
  logic [W-1:0]   op_r1, op_r2;
  logic           op_ci;
  logic [W:0]     sum;

  // Round-robin search of req_valid starting at the pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // Accept decision; forced low while reset is held so no grant leaks out.
  always_comb begin
    can_accept    = (slot_q == EMPTY) || bus.rsp_ready;
    accept        = rst_n && can_accept && found;
    bus.req_ready = accept ? (NREQ'(1) << win) : '0;
  end

  // Winner operand mux and the shared W+1-bit add.
  always_comb begin
    op_r1 = bus.req_r1[win*W +: W];
    op_r2 = bus.req_r2[win*W +: W];
    op_ci = bus.req_ci[win];
    sum   = {1'b0, op_r1} + {1'b0, op_r2} + {{W{1'b0}}, op_ci};
  end

  // Slot, payload, pointer and busy-counter next state.
  always_comb begin
    slot_d  = slot_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    res_d   = res_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    if (accept) begin
      slot_d  = FULL;
      id_d    = win;
      res_d   = sum[W-1:0];
      carry_d = sum[W];
      ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end else if ((slot_q == FULL) && bus.rsp_ready) begin
      slot_d = EMPTY;
    end
    if ((|bus.req_valid) && !accept && (busy_q != 8'hFF)) begin
      busy_d = busy_q + 8'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
    end
  end

  // Output mapping.
  always_comb begin
    bus.rsp_valid  = (slot_q == FULL);
    bus.rsp_id     = id_q;
    bus.rsp_result = res_q;
    bus.rsp_carry  = carry_q;
    bus.busy_cnt   = busy_q;
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus
// random traffic against a behavioural model of grants, slot and counter.
module tb_adder_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // Behavioural model state.
  bit m_valid;
  int m_id, m_res, m_carry, m_ptr, m_busy;

  adder_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  adder_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_res = 0; m_carry = 0; m_ptr = 0; m_busy = 0;
  endtask

  // Valid requester closest to the pointer going upward with wrap, or -1.
  function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
    int best, bestd, d;
    best = -1; bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        d = (i - ptr + NREQ) % NREQ;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input int r1, input int r2, input bit ci);
    bus.req_r1[i*W +: W] = W'(r1);
    bus.req_r2[i*W +: W] = W'(r2);
    bus.req_ci[i]        = ci;
  endtask

  // Called with clk low and inputs already driven; checks, clocks, updates model.
  task automatic step();
    int  w, s;
    bit  acc, any;
    #1;
    w   = model_winner(bus.req_valid, m_ptr);
    acc = (w >= 0) && (!m_valid || bus.rsp_ready);
    any = |bus.req_valid;
    check("req_ready",  bus.req_ready,  acc ? (32'd1 << w) : 32'd0);
    check("rsp_valid",  bus.rsp_valid,  m_valid);
    check("rsp_id",     bus.rsp_id,     m_id);
    check("rsp_result", bus.rsp_result, m_res);
    check("rsp_carry",  bus.rsp_carry,  m_carry);
    check("busy_cnt",   bus.busy_cnt,   m_busy);
    s = 0;
    if (acc) s = int'((bus.req_r1 >> (W*w)) & 15) + int'((bus.req_r2 >> (W*w)) & 15) + int'(bus.req_ci[w]);
    @(posedge clk);
    if (acc) begin
      m_valid = 1; m_id = w; m_res = s % 16; m_carry = s / 16; m_ptr = (w + 1) % NREQ;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 0;
    end
    if (any && !acc && m_busy < 255) m_busy++;
    @(negedge clk);
  endtask

  initial begin
    int b0;
    n_checks = 0; n_fail = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_r1    = $urandom;
    bus.req_r2    = $urandom;
    bus.req_ci    = '0;
    bus.rsp_ready = 1'b1;

    // Reset with everyone requesting: no grant may leak out.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy",      bus.busy_cnt,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order 0,1,2,3,0 at full throughput.
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_order", bus.req_ready, 32'd1 << (i % NREQ));
      check("rr_valid", bus.rsp_valid, (i > 0) ? 1 : 0);
      step();
    end

    // Carry out of the top bit: F + 1 + 1 from requester 2.
    bus.req_valid = '0; step();
    set_req(2, 4'hF, 4'h1, 1'b1);
    bus.req_valid = 4'b0100; step();
    bus.req_valid = '0; bus.rsp_ready = 1'b0;
    #1;
    check("r2_result", bus.rsp_result, 4'h1);
    check("r2_carry",  bus.rsp_carry,  1);
    check("r2_id",     bus.rsp_id,     2);
    step();

    // Backpressure: result held stable, busy counts, grant resumes on ready.
    bus.rsp_ready = 1'b1; step();
    b0 = m_busy;
    set_req(1, 4'h5, 4'h3, 1'b0);
    bus.req_valid = 4'b0010; step();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_result", bus.rsp_result, 4'h8);
      check("hold_carry",  bus.rsp_carry,  0);
      check("hold_ready",  bus.req_ready,  0);
      step();
    end
    check("hold_busy", bus.busy_cnt, b0 + 5);
    bus.rsp_ready = 1'b1;
    #1;
    check("bypass_grant", bus.req_ready, 4'b0010);
    step();

    // Pointer at 1 with requesters 0 and 3 pending: 3 wins, then 0.
    bus.req_valid = 4'b0001; step();
    bus.req_valid = 4'b1001;
    #1; check("ptr1_grant3", bus.req_ready, 4'b1000); step();
    #1; check("ptr0_grant0", bus.req_ready, 4'b0001); step();

    // Saturation of the busy counter.
    bus.req_valid = 4'b0010; bus.rsp_ready = 1'b0;
    repeat (300) step();
    #1; check("busy_sat", bus.busy_cnt, 255);

    // Asynchronous reset while holding result A.
    bus.req_valid = '0; bus.rsp_ready = 1'b1; step();
    set_req(0, 4'h5, 4'h5, 1'b0);
    bus.req_valid = 4'b0001; step();
    bus.req_valid = '1; bus.rsp_ready = 1'b0;
    #1; check("pre_rst_result", bus.rsp_result, 4'hA);
    check("pre_rst_valid", bus.rsp_valid, 1);
    #1; rst_n = 1'b0;
    #1;
    check("arst_valid",  bus.rsp_valid,  0);
    check("arst_result", bus.rsp_result, 0);
    check("arst_busy",   bus.busy_cnt,   0);
    check("arst_ready",  bus.req_ready,  0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    bus.rsp_ready = 1'b1;
    #1; check("post_rst_ptr0", bus.req_ready, 4'b0001);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.req_valid = NREQ'($urandom);
      bus.req_r1    = (NREQ*W)'($urandom);
      bus.req_r2    = (NREQ*W)'($urandom);
      bus.req_ci    = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
